systolic_os_array: RTL

// Parametrised output-stationary systolic MAC array; successor to the fixed 8x8 PE grid.

---
 rtl/sa_pkg.sv | 43 ++++
 rtl/sa_pe.sv | 52 +++++
 rtl/systolic_os_array.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    FLUSH   = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } sa_state_e;

  // Widest operand/product the helper can extend; DW <= MAX_DW, AW <= MAX_AW.
  localparam int MAX_DW = 32;
  localparam int MAX_AW = 64;

  // Flush length for the default 8x8 grid; instances use flush_cyc().
  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int FLUSH_CYC = DEF_ROWS + DEF_COLS - 1;

  // Cycles for the last operand pair to reach the far corner PE.
  function automatic int flush_cyc(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Product of two dw-bit operands, sign- or zero-extended first; the caller
  // truncates to AW, which gives the required modulo-2^AW result.
  function automatic logic [MAX_AW-1:0] ext_prod(input logic [MAX_DW-1:0] a,
                                                 input logic [MAX_DW-1:0] w,
                                                 input int dw,
                                                 input logic sgn);
    logic [MAX_AW-1:0] ax;
    logic [MAX_AW-1:0] wx;
    ax = MAX_AW'(a);
    wx = MAX_AW'(w);
    if (sgn) begin
      ax = MAX_AW'($signed(ax << (MAX_AW - dw)) >>> (MAX_AW - dw));
      wx = MAX_AW'($signed(wx << (MAX_AW - dw)) >>> (MAX_AW - dw));
    end
    return ax * wx;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: forwards operands/tags right and down, accumulates
// locally, and shifts its accumulator up the column during drain.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift,
  input  logic [DW-1:0] a_in,
  input  logic          a_vld_in,
  input  logic [DW-1:0] w_in,
  input  logic          w_vld_in,
  input  logic [AW-1:0] acc_in,
  output logic [DW-1:0] a_out,
  output logic          a_vld_out,
  output logic [DW-1:0] w_out,
  output logic          w_vld_out,
  output logic [AW-1:0] acc
);

  logic [AW-1:0] prod;

  assign prod = AW'(ext_prod(MAX_DW'(a_in), MAX_DW'(w_in), DW, SIGNED != 0));

  // Operand forwarding plus clear / drain-shift / MAC on the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      w_out     <= '0;
      w_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      w_out     <= w_in;
      w_vld_out <= w_vld_in;
      if (clr)
        acc <= '0;
      else if (shift)
        acc <= acc_in;
      else if (a_vld_in && w_vld_in)
        acc <= acc + prod;
    end
  end

endmodule

// File: rtl/systolic_os_array.sv
// Output-stationary ROWS x COLS MAC array with input skewing, bubble-tolerant
// streaming and a row-serial valid/ready drain port.
module systolic_os_array
  import sa_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int KW     = 16,
  parameter int SIGNED = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [KW-1:0]                          k_len,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ROWS*DW-1:0]                     a_vec,
  input  logic [COLS*DW-1:0]                     w_vec,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [COLS*AW-1:0]                     out_data,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0]   out_row,
  output logic                                   busy,
  output logic                                   done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL = flush_cyc(ROWS, COLS);
  localparam int FW = $clog2(FL + 1);

  sa_state_e     state, nxt;
  logic [KW-1:0] k_len_q, k_cnt;
  logic [FW-1:0] fl_cnt;
  logic [RW-1:0] row_cnt;
  logic          xfer, beat, acc_start, last_row;

  // Operand, tag and accumulator buses between neighbouring PEs
  logic [DW-1:0] a_bus  [ROWS][COLS+1];
  logic          av_bus [ROWS][COLS+1];
  logic [DW-1:0] w_bus  [ROWS+1][COLS];
  logic          wv_bus [ROWS+1][COLS];
  logic [AW-1:0] acc_bus [ROWS+1][COLS];
  logic [ROWS-1:0] unused_a;
  logic [COLS-1:0] unused_w;

  assign xfer      = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  assign acc_start = (state == IDLE) & start;
  assign last_row  = (row_cnt == RW'(ROWS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (k_len != '0) ? COMPUTE : FLUSH;
      COMPUTE: if (xfer && (k_cnt == k_len_q - KW'(1))) nxt = FLUSH;
      FLUSH:   if (fl_cnt == '0) nxt = DRAIN;
      DRAIN:   if (beat && last_row) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    in_ready  = (state == COMPUTE) && (k_cnt != k_len_q);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Reduction, flush and drain-row counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_q <= '0;
      k_cnt   <= '0;
      fl_cnt  <= '0;
      row_cnt <= '0;
    end else begin
      if (acc_start) begin
        k_len_q <= k_len;
        k_cnt   <= '0;
      end else if (xfer) begin
        k_cnt <= k_cnt + KW'(1);
      end
      if ((nxt == FLUSH) && (state != FLUSH))
        fl_cnt <= FW'(FL - 1);
      else if ((state == FLUSH) && (fl_cnt != '0))
        fl_cnt <= fl_cnt - FW'(1);
      if (state != DRAIN)
        row_cnt <= '0;
      else if (beat)
        row_cnt <= row_cnt + RW'(1);
    end
  end

  assign out_row = row_cnt;

  // Row 0 of the drain chain is the output row; zero whenever not presenting
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++)
      if (out_valid) out_data[c*AW +: AW] = acc_bus[0][c];
  end

  // Activation skew: row r enters r cycles late
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_z
      assign a_bus[0][0]  = a_vec[DW-1:0];
      assign av_bus[0][0] = xfer;
    end else begin : g_d
      logic [DW-1:0] sd [r];
      logic          sv [r];
      // r-stage delay line for row r data and tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < r; i++) begin
            sd[i] <= '0;
            sv[i] <= 1'b0;
          end
        end else begin
          sd[0] <= a_vec[r*DW +: DW];
          sv[0] <= xfer;
          for (int i = 1; i < r; i++) begin
            sd[i] <= sd[i-1];
            sv[i] <= sv[i-1];
          end
        end
      end
      assign a_bus[r][0]  = sd[r-1];
      assign av_bus[r][0] = sv[r-1];
    end
    assign unused_a[r] = ^{av_bus[r][COLS], a_bus[r][COLS]};
  end

  // Weight skew: column c enters c cycles late
  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    if (c == 0) begin : g_z
      assign w_bus[0][0]  = w_vec[DW-1:0];
      assign wv_bus[0][0] = xfer;
    end else begin : g_d
      logic [DW-1:0] sd [c];
      logic          sv [c];
      // c-stage delay line for column c data and tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < c; i++) begin
            sd[i] <= '0;
            sv[i] <= 1'b0;
          end
        end else begin
          sd[0] <= w_vec[c*DW +: DW];
          sv[0] <= xfer;
          for (int i = 1; i < c; i++) begin
            sd[i] <= sd[i-1];
            sv[i] <= sv[i-1];
          end
        end
      end
      assign w_bus[0][c]  = sd[c-1];
      assign wv_bus[0][c] = sv[c-1];
    end
    assign acc_bus[ROWS][c] = '0;
    assign unused_w[c]      = ^{wv_bus[ROWS][c], w_bus[ROWS][c]};
  end

  // PE grid
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_start),
        .shift     (beat),
        .a_in      (a_bus[r][c]),
        .a_vld_in  (av_bus[r][c]),
        .w_in      (w_bus[r][c]),
        .w_vld_in  (wv_bus[r][c]),
        .acc_in    (acc_bus[r+1][c]),
        .a_out     (a_bus[r][c+1]),
        .a_vld_out (av_bus[r][c+1]),
        .w_out     (w_bus[r+1][c]),
        .w_vld_out (wv_bus[r+1][c]),
        .acc       (acc_bus[r][c])
      );
    end
  end

endmodule
